// File: rtl/ode_io_pkg.sv
// ode_io_pkg: phase encoding shared by the ODE I/O sequencer, its RAM mux and the bench.
package ode_io_pkg;
  localparam logic [2:0] PHASE_IDLE = 3'd0;
  localparam logic [2:0] PHASE_LOAD = 3'd1;
  localparam logic [2:0] PHASE_SOLVE = 3'd2;
  localparam logic [2:0] PHASE_SEND = 3'd3;
  localparam logic [2:0] PHASE_DONE = 3'd4;
  localparam logic [2:0] PHASE_ERR = 3'd5;
  typedef enum logic [2:0] {
    IDLE = PHASE_IDLE,
    LOAD = PHASE_LOAD,
    SOLVE = PHASE_SOLVE,
    SEND = PHASE_SEND,
    DONE = PHASE_DONE,
    ERR = PHASE_ERR
  } state_t;
endpackage

// File: rtl/ode_io_sequencer_if.sv
// ode_io_sequencer_if: CPU handshake, done pulses and RAM port signals around the sequencer.
interface ode_io_sequencer_if #(
  parameter int ADDRESS_WIDTH = 13,
  parameter int DATA_WIDTH = 64,
  parameter int PKT_W = 8
);
  logic INT, Load_Process, Abort;
  logic Done_Loading, Packet_Done, Solver_Done, Done_Sending;
  logic Dec_WR_En, Slv_WR_En;
  logic [ADDRESS_WIDTH-1:0] Dec_Addr_WR, Slv_Addr_WR;
  logic [DATA_WIDTH-1:0] Dec_Data_WR, Slv_Data_WR;
  logic [ADDRESS_WIDTH-1:0] Slv_Addr_RD_A, Slv_Addr_RD_B, Snd_Addr_RD_A, Snd_Addr_RD_B;
  logic RAM_WR_Enable;
  logic [ADDRESS_WIDTH-1:0] RAM_Address_WR, RAM_Address_RD_A, RAM_Address_RD_B;
  logic [DATA_WIDTH-1:0] RAM_Data_WR;
  logic Loading_Enable, Solver_Start, Sending_Enable, Done_Processing, Error;
  logic [2:0] Phase;
  logic [PKT_W-1:0] Packet_Count;
  modport slave (
    input INT, Load_Process, Abort, Done_Loading, Packet_Done, Solver_Done, Done_Sending,
    input Dec_WR_En, Dec_Addr_WR, Dec_Data_WR, Slv_WR_En, Slv_Addr_WR, Slv_Data_WR,
    input Slv_Addr_RD_A, Slv_Addr_RD_B, Snd_Addr_RD_A, Snd_Addr_RD_B,
    output RAM_WR_Enable, RAM_Address_WR, RAM_Data_WR, RAM_Address_RD_A, RAM_Address_RD_B,
    output Loading_Enable, Solver_Start, Sending_Enable, Done_Processing, Phase, Packet_Count, Error
  );
  modport master (
    output INT, Load_Process, Abort, Done_Loading, Packet_Done, Solver_Done, Done_Sending,
    output Dec_WR_En, Dec_Addr_WR, Dec_Data_WR, Slv_WR_En, Slv_Addr_WR, Slv_Data_WR,
    output Slv_Addr_RD_A, Slv_Addr_RD_B, Snd_Addr_RD_A, Snd_Addr_RD_B,
    input RAM_WR_Enable, RAM_Address_WR, RAM_Data_WR, RAM_Address_RD_A, RAM_Address_RD_B,
    input Loading_Enable, Solver_Start, Sending_Enable, Done_Processing, Phase, Packet_Count, Error
  );
endinterface

// File: rtl/ode_io_ram_mux.sv
// ode_io_ram_mux: hands the RAM ports to decoder, solver or sender according to the registered phase.
module ode_io_ram_mux import ode_io_pkg::*; #(
  parameter int ADDRESS_WIDTH = 13,
  parameter int DATA_WIDTH = 64
) (
  input  state_t state,
  input  logic dec_we,
  input  logic [ADDRESS_WIDTH-1:0] dec_addr,
  input  logic [DATA_WIDTH-1:0] dec_data,
  input  logic slv_we,
  input  logic [ADDRESS_WIDTH-1:0] slv_addr,
  input  logic [DATA_WIDTH-1:0] slv_data,
  input  logic [ADDRESS_WIDTH-1:0] slv_rd_a, slv_rd_b, snd_rd_a, snd_rd_b,
  output logic ram_we,
  output logic [ADDRESS_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic [ADDRESS_WIDTH-1:0] ram_rd_a, ram_rd_b
);
  always_comb begin
    ram_we = state == LOAD ? dec_we : state == SOLVE ? slv_we : 1'b0;
    ram_addr = state == LOAD ? dec_addr : state == SOLVE ? slv_addr : '0;
    ram_data = state == LOAD ? dec_data : state == SOLVE ? slv_data : '0;
    ram_rd_a = state == SOLVE ? slv_rd_a : state == SEND ? snd_rd_a : '0;
    ram_rd_b = state == SOLVE ? slv_rd_b : state == SEND ? snd_rd_b : '0;
  end
endmodule

// File: rtl/ode_io_sequencer.sv
// ode_io_sequencer: LOAD/SOLVE/SEND phase controller; ODE_IO_WATCHDOG_EN adds a stall watchdog into ERR.
module ode_io_sequencer import ode_io_pkg::*; #(
  parameter int ADDRESS_WIDTH = 13,
  parameter int DATA_WIDTH = 64,
  parameter int PKT_W = 8,
  parameter int WDOG_W = 16
) (
  input logic CLK,
  input logic RST,
  ode_io_sequencer_if.slave bus
);
  state_t state, nxt;
  logic [PKT_W-1:0] cnt;
  logic err, start, active, expired;
  assign active = state inside {LOAD, SOLVE, SEND};
`ifdef ODE_IO_WATCHDOG_EN
  logic [WDOG_W-1:0] wd;
  assign expired = active & (&wd);
  always_ff @(posedge CLK or negedge RST)
    if (!RST) wd <= '0;
    else wd <= (nxt != state || !active) ? '0 : wd + 1'b1;
`else
  logic unused_wdog;
  assign unused_wdog = WDOG_W != 0;
  assign expired = 1'b0;
`endif
  always_comb begin
    nxt = state;
    case (state)
      IDLE: nxt = (bus.INT & bus.Load_Process) ? LOAD : IDLE;
      LOAD: nxt = bus.Done_Loading ? SOLVE : LOAD;
      SOLVE: nxt = bus.Solver_Done ? SEND : SOLVE;
      SEND: nxt = bus.Done_Sending ? DONE : SEND;
      DONE: nxt = bus.INT ? (bus.Load_Process ? LOAD : IDLE) : DONE;
      ERR: nxt = ERR;
      default: nxt = IDLE;
    endcase
    if (expired) nxt = ERR;
    if (bus.Abort) nxt = IDLE;
  end
  // Packet_Done alongside Done_Loading still counts: nxt is SOLVE then, so no clear.
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      state <= IDLE;
      cnt <= '0;
      err <= 1'b0;
      start <= 1'b0;
    end else begin
      state <= nxt;
      start <= (nxt == SOLVE) && (state != SOLVE);
      if ((nxt != state) && (nxt == LOAD || nxt == IDLE)) cnt <= '0;
      else if (state == LOAD && bus.Packet_Done && !(&cnt)) cnt <= cnt + 1'b1;
      if (state == IDLE && nxt == LOAD) err <= 1'b0;
      else if (!bus.Abort && (expired || (state == LOAD && (bus.Solver_Done || (bus.Packet_Done && (&cnt))))))
        err <= 1'b1;
    end
  assign bus.Phase = state;
  assign bus.Packet_Count = cnt;
  assign bus.Error = err;
  assign bus.Solver_Start = start;
  assign bus.Loading_Enable = state == LOAD;
  assign bus.Sending_Enable = state == SEND;
  assign bus.Done_Processing = state == DONE;
  ode_io_ram_mux #(.ADDRESS_WIDTH(ADDRESS_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_mux (
    .state(state),
    .dec_we(bus.Dec_WR_En), .dec_addr(bus.Dec_Addr_WR), .dec_data(bus.Dec_Data_WR),
    .slv_we(bus.Slv_WR_En), .slv_addr(bus.Slv_Addr_WR), .slv_data(bus.Slv_Data_WR),
    .slv_rd_a(bus.Slv_Addr_RD_A), .slv_rd_b(bus.Slv_Addr_RD_B),
    .snd_rd_a(bus.Snd_Addr_RD_A), .snd_rd_b(bus.Snd_Addr_RD_B),
    .ram_we(bus.RAM_WR_Enable), .ram_addr(bus.RAM_Address_WR), .ram_data(bus.RAM_Data_WR),
    .ram_rd_a(bus.RAM_Address_RD_A), .ram_rd_b(bus.RAM_Address_RD_B)
  );
endmodule

// File: tb/tb_ode_io_sequencer.sv
// tb_ode_io_sequencer: scoreboard bench for the phase sequencer (watchdog case under ODE_IO_WATCHDOG_EN).
module tb_ode_io_sequencer;
  import ode_io_pkg::*;
  localparam int AW = 13, DW = 64, PW = 2, WW = 4;
  localparam int PH = 0, CNT = 1, ERF = 2, ST = 3, LE = 4, SE = 5, DP = 6, WE = 7, WA = 8, WD = 9, RA = 10;
  typedef struct {
    string tag;
    int sig;
    logic [63:0] exp;
  } item_t;
  logic CLK = 1'b0;
  logic RST;
  int checks = 0, failures = 0;
  item_t sb[$];
  ode_io_sequencer_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .PKT_W(PW)) bus ();
  ode_io_sequencer #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .PKT_W(PW), .WDOG_W(WW)) dut (
    .CLK(CLK), .RST(RST), .bus(bus)
  );
  always #5 CLK = ~CLK;
  function automatic logic [63:0] obs(int sig);
    case (sig)
      PH: return 64'(bus.Phase);
      CNT: return 64'(bus.Packet_Count);
      ERF: return 64'(bus.Error);
      ST: return 64'(bus.Solver_Start);
      LE: return 64'(bus.Loading_Enable);
      SE: return 64'(bus.Sending_Enable);
      DP: return 64'(bus.Done_Processing);
      WE: return 64'(bus.RAM_WR_Enable);
      WA: return 64'(bus.RAM_Address_WR);
      WD: return bus.RAM_Data_WR;
      default: return 64'(bus.RAM_Address_RD_A);
    endcase
  endfunction
  task automatic check(string tag, logic [63:0] got, logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, want);
    end
  endtask
  task automatic expect_val(string tag, int sig, logic [63:0] v);
    item_t e;
    e.tag = tag;
    e.sig = sig;
    e.exp = v;
    sb.push_back(e);
  endtask
  task automatic drain();
    item_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, obs(e.sig), e.exp);
    end
  endtask
  task automatic tick();
    @(posedge CLK);
    #1;
    drain();
  endtask
  task automatic clear_pulses();
    bus.INT = 0; bus.Load_Process = 0; bus.Abort = 0;
    bus.Done_Loading = 0; bus.Packet_Done = 0; bus.Solver_Done = 0; bus.Done_Sending = 0;
  endtask
  initial begin
    clear_pulses();
    bus.Dec_WR_En = 0; bus.Dec_Addr_WR = '0; bus.Dec_Data_WR = '0;
    bus.Slv_WR_En = 0; bus.Slv_Addr_WR = '0; bus.Slv_Data_WR = '0;
    bus.Slv_Addr_RD_A = '0; bus.Slv_Addr_RD_B = '0; bus.Snd_Addr_RD_A = '0; bus.Snd_Addr_RD_B = '0;
    RST = 1; #3 RST = 0; #2;
    expect_val("rst_phase", PH, PHASE_IDLE); expect_val("rst_cnt", CNT, 0); expect_val("rst_err", ERF, 0);
    expect_val("rst_start", ST, 0); expect_val("rst_we", WE, 0); expect_val("rst_dp", DP, 0);
    drain();
    #4 RST = 1;
    tick();
    bus.INT = 1; bus.Load_Process = 1;
    expect_val("load_phase", PH, PHASE_LOAD); expect_val("load_en", LE, 1);
    tick(); clear_pulses();
    bus.Dec_WR_En = 1; bus.Dec_Addr_WR = 13'h010; bus.Dec_Data_WR = 64'hDEAD;
    bus.Slv_WR_En = 1; bus.Slv_Addr_WR = 13'h1FF; bus.Slv_Data_WR = 64'hBEEF;
    bus.Slv_Addr_RD_A = 13'h055; bus.Snd_Addr_RD_A = 13'h0AA;
    #1;
    expect_val("load_mux_addr", WA, 'h010); expect_val("load_mux_data", WD, 'hDEAD);
    expect_val("load_mux_we", WE, 1); expect_val("load_rd_a", RA, 0);
    drain();
    for (int i = 1; i <= 2; i++) begin
      bus.Packet_Done = 1;
      expect_val("pkt_cnt", CNT, 64'(i));
      tick(); clear_pulses();
    end
    bus.Packet_Done = 1; bus.Done_Loading = 1;
    expect_val("pkt_with_done_cnt", CNT, 3); expect_val("solve_phase", PH, PHASE_SOLVE);
    expect_val("solve_start", ST, 1); expect_val("solve_mux_addr", WA, 'h1FF);
    expect_val("solve_mux_data", WD, 'hBEEF); expect_val("solve_rd_a", RA, 'h055); expect_val("solve_le", LE, 0);
    tick(); clear_pulses();
    expect_val("start_one_cycle", ST, 0); expect_val("solve_hold", PH, PHASE_SOLVE);
    tick();
    bus.Solver_Done = 1;
    expect_val("send_phase", PH, PHASE_SEND); expect_val("send_en", SE, 1);
    expect_val("send_we", WE, 0); expect_val("send_wa", WA, 0); expect_val("send_rd_a", RA, 'h0AA);
    tick(); clear_pulses();
    bus.Done_Sending = 1;
    expect_val("done_phase", PH, PHASE_DONE); expect_val("done_dp", DP, 1);
    expect_val("done_cnt", CNT, 3); expect_val("done_err", ERF, 0); expect_val("done_rd_a", RA, 0);
    tick(); clear_pulses();
    bus.INT = 1;
    expect_val("done_to_idle", PH, PHASE_IDLE); expect_val("idle_cnt", CNT, 0); expect_val("idle_dp", DP, 0);
    tick(); clear_pulses();
    bus.INT = 1; bus.Load_Process = 1;
    expect_val("load2_phase", PH, PHASE_LOAD);
    tick(); clear_pulses();
    for (int i = 1; i <= 5; i++) begin
      bus.Packet_Done = 1;
      expect_val("sat_cnt", CNT, 64'(i > 3 ? 3 : i)); expect_val("sat_err", ERF, 64'(i > 3));
      tick(); clear_pulses();
    end
    bus.Done_Sending = 1;
    expect_val("stray_done_sending", PH, PHASE_LOAD);
    tick(); clear_pulses();
    bus.Done_Loading = 1;
    expect_val("sat_solve", PH, PHASE_SOLVE); expect_val("err_sticky", ERF, 1);
    tick(); clear_pulses();
    bus.Solver_Done = 1;
    expect_val("sat_send", PH, PHASE_SEND);
    tick(); clear_pulses();
    bus.Abort = 1; bus.Done_Sending = 1;
    expect_val("abort_phase", PH, PHASE_IDLE); expect_val("abort_dp", DP, 0); expect_val("abort_err", ERF, 1);
    tick(); clear_pulses();
    bus.INT = 1; bus.Load_Process = 1;
    expect_val("err_clear_phase", PH, PHASE_LOAD); expect_val("err_clear", ERF, 0);
    tick(); clear_pulses();
    bus.Solver_Done = 1;
    expect_val("early_solver_phase", PH, PHASE_LOAD); expect_val("early_solver_err", ERF, 1);
    tick(); clear_pulses();
    bus.Done_Loading = 1;
    expect_val("pre_rst_start", ST, 1);
    tick(); clear_pulses();
    #3 RST = 0; #1;
    expect_val("async_rst_phase", PH, PHASE_IDLE); expect_val("async_rst_start", ST, 0);
    expect_val("async_rst_we", WE, 0); expect_val("async_rst_err", ERF, 0);
    drain();
    #1 RST = 1;
    tick();
`ifdef ODE_IO_WATCHDOG_EN
    bus.INT = 1; bus.Load_Process = 1;
    tick(); clear_pulses();
    bus.Done_Loading = 1;
    expect_val("wd_solve", PH, PHASE_SOLVE);
    tick(); clear_pulses();
    for (int i = 1; i <= 16; i++) begin
      if (i == 15) expect_val("wd_not_yet", PH, PHASE_SOLVE);
      if (i == 16) begin
        expect_val("wd_phase", PH, PHASE_ERR); expect_val("wd_err", ERF, 1);
        expect_val("wd_we", WE, 0); expect_val("wd_le", LE, 0);
      end
      tick();
    end
    expect_val("wd_stays_err", PH, PHASE_ERR);
    tick();
    bus.Abort = 1;
    expect_val("wd_abort", PH, PHASE_IDLE); expect_val("wd_abort_err", ERF, 1);
    tick(); clear_pulses();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
